// File: rtl/lsm_pkg.sv
// Shared definitions for the liquid-state-machine reservoir.
// The phase codes below are decoded by the neuron RTL as well as by the sequencer.
package lsm_pkg;

    typedef logic [2:0] phase_t;

    localparam phase_t PH_CLEAR   = 3'b000;
    localparam phase_t PH_LEAK    = 3'b001;
    localparam phase_t PH_INPUT   = 3'b010;
    localparam phase_t PH_RECUR   = 3'b011;
    localparam phase_t PH_INTEG   = 3'b100;
    localparam phase_t PH_FIRE    = 3'b101;
    localparam phase_t PH_COLLECT = 3'b110;
    localparam phase_t PH_IDLE    = 3'b111;

    localparam int DEF_N_IN   = 8;
    localparam int DEF_N_RES  = 16;
    localparam int DEF_CNT_W  = 6;
    localparam int DEF_STEP_W = 10;

endpackage

// File: rtl/lsm_index_counter.sv
// Loadable 1..LIMIT index counter; wraps back to 0 after LIMIT so the index
// bus reads 0 whenever its phase is not active.
module lsm_index_counter #(
    parameter int LIMIT = 8,
    parameter int CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             load,
    input  logic             adv,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

    // NOTE: sequential state uses <= only, so every reader of cnt sees the pre-edge value.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(1);
        end else if (adv) begin
            cnt <= last ? '0 : cnt + CNT_W'(1);
        end
    end

    assign last = (cnt == LIM);

endmodule

// File: rtl/lsm_phase_sequencer.sv
// Reservoir phase sequencer: walks every neuron through one timestep per input vector.
// Optional macro LSM_SKIP_SILENT_EN skips INPUT/RECUR when their spike vector is all zero.
module lsm_phase_sequencer
    import lsm_pkg::*;
#(
    parameter int N_IN   = DEF_N_IN,
    parameter int N_RES  = DEF_N_RES,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int STEP_W = DEF_STEP_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              start,
    input  logic [STEP_W-1:0] num_steps,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   in_spikes,
    input  logic [N_RES-1:0]  neuron_spikes,
    output logic [2:0]        state,
    output logic [CNT_W-1:0]  cnt_i,
    output logic [CNT_W-1:0]  cnt_r,
    output logic [N_IN-1:0]   InputSpike,
    output logic [N_RES-1:0]  InternalSpike,
    output logic              out_valid,
    output logic [N_RES-1:0]  step_spikes,
    output logic              busy,
    output logic              done
);

    typedef enum logic [3:0] {
        S_IDLE, S_CLEAR, S_FETCH, S_LEAK, S_INPUT, S_RECUR, S_INTEG, S_FIRE, S_COLLECT
    } fsm_t;

    fsm_t              fsm;
    logic [STEP_W-1:0] steps_q;
    logic [STEP_W-1:0] step_cnt;
    logic [STEP_W-1:0] step_next;
    logic              skip_input, skip_recur;
    logic              i_load, i_adv, i_last;
    logic              r_load, r_adv, r_last;

`ifdef LSM_SKIP_SILENT_EN
    assign skip_input = (InputSpike == '0);
    assign skip_recur = (InternalSpike == '0);
`else
    assign skip_input = 1'b0;
    assign skip_recur = 1'b0;
`endif

    assign step_next = step_cnt + STEP_W'(1);
    assign i_load    = (fsm == S_LEAK) && !skip_input;
    assign i_adv     = (fsm == S_INPUT);
    assign r_load    = !skip_recur &&
                       (((fsm == S_LEAK) && skip_input) || ((fsm == S_INPUT) && i_last));
    assign r_adv     = (fsm == S_RECUR);

    lsm_index_counter #(.LIMIT(N_IN), .CNT_W(CNT_W)) u_cnt_i (
        .Clk(Clk), .Rst(Rst), .load(i_load), .adv(i_adv), .cnt(cnt_i), .last(i_last)
    );

    lsm_index_counter #(.LIMIT(N_RES), .CNT_W(CNT_W)) u_cnt_r (
        .Clk(Clk), .Rst(Rst), .load(r_load), .adv(r_adv), .cnt(cnt_r), .last(r_last)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            fsm           <= S_IDLE;
            state         <= PH_IDLE;
            steps_q       <= '0;
            step_cnt      <= '0;
            InputSpike    <= '0;
            InternalSpike <= '0;
            step_spikes   <= '0;
            in_ready      <= 1'b0;
            out_valid     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low here, so any branch that sets them lasts one cycle.
            out_valid <= 1'b0;
            done      <= 1'b0;
            case (fsm)
                S_IDLE: if (start) begin
                    steps_q       <= (num_steps == '0) ? STEP_W'(1) : num_steps;
                    step_cnt      <= '0;
                    InternalSpike <= '0;
                    busy          <= 1'b1;
                    state         <= PH_CLEAR;
                    fsm           <= S_CLEAR;
                end
                S_CLEAR: begin
                    in_ready <= 1'b1;
                    state    <= PH_IDLE;
                    fsm      <= S_FETCH;
                end
                S_FETCH: if (in_valid && in_ready) begin
                    InputSpike <= in_spikes;
                    in_ready   <= 1'b0;
                    state      <= PH_LEAK;
                    fsm        <= S_LEAK;
                end
                S_LEAK: begin
                    if (!skip_input) begin
                        state <= PH_INPUT;
                        fsm   <= S_INPUT;
                    end else if (!skip_recur) begin
                        state <= PH_RECUR;
                        fsm   <= S_RECUR;
                    end else begin
                        state <= PH_INTEG;
                        fsm   <= S_INTEG;
                    end
                end
                S_INPUT: if (i_last) begin
                    state <= skip_recur ? PH_INTEG : PH_RECUR;
                    fsm   <= skip_recur ? S_INTEG : S_RECUR;
                end
                S_RECUR: if (r_last) begin
                    state <= PH_INTEG;
                    fsm   <= S_INTEG;
                end
                S_INTEG: begin
                    state <= PH_FIRE;
                    fsm   <= S_FIRE;
                end
                S_FIRE: begin
                    state <= PH_COLLECT;
                    fsm   <= S_COLLECT;
                end
                S_COLLECT: begin
                    InternalSpike <= neuron_spikes;
                    step_spikes   <= neuron_spikes;
                    out_valid     <= 1'b1;
                    step_cnt      <= step_next;
                    state         <= PH_IDLE;
                    if (step_next == steps_q) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                        fsm  <= S_IDLE;
                    end else begin
                        in_ready <= 1'b1;
                        fsm      <= S_FETCH;
                    end
                end
                default: begin
                    state <= PH_IDLE;
                    fsm   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsm_phase_sequencer.sv
// Randomized bench for lsm_phase_sequencer against a per-cycle phase model
// derived from the timestep rules.
module tb_lsm_phase_sequencer;
    import lsm_pkg::*;

`ifdef LSM_SKIP_SILENT_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        Clk;
    logic        Rst;
    logic        start;
    logic [9:0]  num_steps;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_spikes;
    logic [15:0] neuron_spikes;
    logic [2:0]  state;
    logic [5:0]  cnt_i;
    logic [5:0]  cnt_r;
    logic [7:0]  InputSpike;
    logic [15:0] InternalSpike;
    logic        out_valid;
    logic [15:0] step_spikes;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    lsm_phase_sequencer dut (
        .Clk(Clk), .Rst(Rst), .start(start), .num_steps(num_steps),
        .in_valid(in_valid), .in_ready(in_ready), .in_spikes(in_spikes),
        .neuron_spikes(neuron_spikes), .state(state), .cnt_i(cnt_i), .cnt_r(cnt_r),
        .InputSpike(InputSpike), .InternalSpike(InternalSpike), .out_valid(out_valid),
        .step_spikes(step_spikes), .busy(busy), .done(done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_cycle(input string tag, input logic [2:0] st, input int ci, input int cr,
                             input bit rdy, input bit bsy, input bit ov, input bit dn);
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".cnt_i"}, 32'(cnt_i), ci);
        chk({tag, ".cnt_r"}, 32'(cnt_r), cr);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
        chk({tag, ".busy"}, 32'(busy), 32'(bsy));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, ".done"}, 32'(done), 32'(dn));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            tick;
            exp_cycle("idle", PH_IDLE, 0, 0, 0, 0, 0, 0);
        end
    endtask

    // One sample: start pulse, then eff timesteps. Returns in the done cycle,
    // or in the idle cycle after an abort at RECUR cnt_r=7 of step abort_step.
    task automatic run_sample(input int ns, input int stall0, input logic [7:0] vec0,
                              input logic [15:0] stub0, input int abort_step, input bit zero_in);
        int          eff;
        int          stall;
        logic [15:0] prev;
        logic [7:0]  vec;
        logic [15:0] stub;
        bit          do_in, do_rc;
        eff  = (ns == 0) ? 1 : ns;
        prev = '0;
        start = 1'b1;
        num_steps = 10'(ns);
        tick;
        start = 1'b0;
        num_steps = 10'($urandom);
        exp_cycle("clear", PH_CLEAR, 0, 0, 0, 1, 0, 0);
        chk("clear.internal", 32'(InternalSpike), 0);
        tick;
        for (int s = 0; s < eff; s++) begin
            vec   = (s == 0) ? vec0  : (zero_in ? 8'h00  : 8'($urandom));
            stub  = (s == 0) ? stub0 : (zero_in ? 16'h0000 : 16'($urandom));
            stall = (s == 0) ? stall0 : (zero_in ? 0 : int'($urandom_range(0, 3)));
            for (int k = 0; k <= stall; k++) begin
                in_valid  = (k == stall);
                in_spikes = in_valid ? vec : 8'($urandom);
                exp_cycle("fetch", PH_IDLE, 0, 0, 1, 1, (s > 0 && k == 0), 0);
                if (s > 0 && k == 0) begin
                    chk("step.spikes", 32'(step_spikes), 32'(prev));
                    chk("step.internal", 32'(InternalSpike), 32'(prev));
                end
                tick;
            end
            in_valid  = 1'b0;
            in_spikes = 8'($urandom);
            exp_cycle("leak", PH_LEAK, 0, 0, 0, 1, 0, 0);
            chk("leak.inspike", 32'(InputSpike), 32'(vec));
            tick;
            do_in = !(SKIP && vec == 8'h00);
            do_rc = !(SKIP && prev == 16'h0000);
            if (do_in) begin
                for (int k = 1; k <= 8; k++) begin
                    exp_cycle("input", PH_INPUT, k, 0, 0, 1, 0, 0);
                    chk("input.internal", 32'(InternalSpike), 32'(prev));
                    start    = (k == 3);
                    in_valid = (k == 3);
                    tick;
                end
                start    = 1'b0;
                in_valid = 1'b0;
            end
            if (do_rc) begin
                for (int k = 1; k <= 16; k++) begin
                    exp_cycle("recur", PH_RECUR, 0, k, 0, 1, 0, 0);
                    chk("recur.internal", 32'(InternalSpike), 32'(prev));
                    if (s == abort_step && k == 7) begin
                        Rst = 1'b1;
                        tick;
                        Rst = 1'b0;
                        exp_cycle("abort", PH_IDLE, 0, 0, 0, 0, 0, 0);
                        chk("abort.inspike", 32'(InputSpike), 0);
                        chk("abort.internal", 32'(InternalSpike), 0);
                        idle(3);
                        return;
                    end
                    tick;
                end
            end
            exp_cycle("integ", PH_INTEG, 0, 0, 0, 1, 0, 0);
            tick;
            exp_cycle("fire", PH_FIRE, 0, 0, 0, 1, 0, 0);
            neuron_spikes = stub;
            tick;
            exp_cycle("collect", PH_COLLECT, 0, 0, 0, 1, 0, 0);
            chk("collect.internal", 32'(InternalSpike), 32'(prev));
            tick;
            neuron_spikes = 16'($urandom);
            prev = stub;
            if (s == eff - 1) begin
                exp_cycle("last", PH_IDLE, 0, 0, 0, 0, 1, 1);
                chk("last.spikes", 32'(step_spikes), 32'(stub));
                chk("last.internal", 32'(InternalSpike), 32'(stub));
            end
        end
    endtask

    initial begin
        Rst           = 1'b1;
        start         = 1'b0;
        num_steps     = '0;
        in_valid      = 1'b0;
        in_spikes     = '0;
        neuron_spikes = '0;
        tick;
        tick;
        Rst = 1'b0;
        exp_cycle("reset", PH_IDLE, 0, 0, 0, 0, 0, 0);
        chk("reset.inspike", 32'(InputSpike), 0);
        chk("reset.internal", 32'(InternalSpike), 0);
        in_valid = 1'b1;
        idle(3);
        in_valid = 1'b0;

        run_sample(1, 0, 8'h81, 16'h0005, -1, 1'b0);
        idle(2);

        run_sample(3, 0, 8'h5a, 16'hA5A5, -1, 1'b0);
        run_sample(2, 1, 8'hc3, 16'h0ff0, -1, 1'b0);
        idle(1);

        run_sample(1, 10, 8'h33, 16'h1234, -1, 1'b0);
        idle(1);

        run_sample(3, 0, 8'h3c, 16'h0f0f, 1, 1'b0);
        run_sample(1, 0, 8'h18, 16'h8001, -1, 1'b0);
        idle(1);

        run_sample(0, 0, 8'h00, 16'h0000, -1, 1'b1);
        idle(1);
        run_sample(0, 2, 8'h7e, 16'h4242, -1, 1'b0);
        idle(1);

        for (int r = 0; r < 4; r++) begin
            run_sample(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                       8'($urandom), 16'($urandom) | 16'h0001, -1, 1'b0);
            idle(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsm_phase_sequencer.md
Name: lsm_phase_sequencer

Overview:
- Central controller for the liquid-state-machine reservoir; drives the shared phase bus (state, cnt_i, cnt_r) to all liquid neurons.
- Fetches one input spike vector per timestep and walks every neuron through the clear, leak, input, recurrent, integrate and fire phases.
- Collects the 16 fired spikes and registers them as the InternalSpike vector for the next timestep.
- Sits between the input pattern buffer and the reservoir neuron array; one instance per reservoir.

Parameters:
- N_IN, 8: input channels; cnt_i runs 1..N_IN.
- N_RES, 16: reservoir neurons; cnt_r runs 1..N_RES.
- CNT_W, 6: width of cnt_i and cnt_r.
- STEP_W, 10: width of the timestep counter.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a sample; ignored while busy=1.
- num_steps  in  STEP_W  timesteps per sample; sampled on start; a value of 0 is treated as 1.
- in_valid  in  1  in_spikes is valid.
- in_ready  out  1  high only in FETCH; transfer happens when in_valid && in_ready.
- in_spikes  in  N_IN  input spike vector for the timestep (bit k = channel k).
- neuron_spikes  in  N_RES  curr_spike outputs of the neuron array.
- state  out  3  phase code to the neurons (registered).
- cnt_i  out  CNT_W  input channel index (registered).
- cnt_r  out  CNT_W  recurrent source index (registered).
- InputSpike  out  N_IN  latched input vector for the current timestep.
- InternalSpike  out  N_RES  spikes latched at the end of the previous timestep.
- out_valid  out  1  one-cycle pulse; step_spikes is valid.
- step_spikes  out  N_RES  equals the newly latched InternalSpike.
- busy  out  1  high from CLEAR through COLLECT of the last step.
- done  out  1  one-cycle pulse after the last COLLECT.

Behaviour:
- Phase codes on state: 000 CLEAR, 001 LEAK, 010 INPUT, 011 RECUR, 100 INTEG, 101 FIRE, 110 COLLECT, 111 IDLE/FETCH. Neurons treat 110 and 111 as no-op.
- Reset values: state=111, cnt_i=0, cnt_r=0, InputSpike=0, InternalSpike=0, in_ready=0, out_valid=0, done=0, busy=0, step counter=0, FSM=IDLE.
- FSM transitions:
  - IDLE: on start, latch num_steps (0 becomes 1), clear the step counter and InternalSpike, then go to CLEAR.
  - CLEAR: 1 cycle, then FETCH.
  - FETCH: in_ready=1, state=111. Waits indefinitely for in_valid. On transfer, latch InputSpike and go to LEAK.
  - LEAK: 1 cycle.
  - INPUT: N_IN cycles with cnt_i = 1, 2, ..., N_IN, one per cycle.
  - RECUR: N_RES cycles with cnt_r = 1..N_RES.
  - INTEG: 1 cycle.
  - FIRE: 1 cycle.
  - COLLECT: 1 cycle.
- COLLECT timing:
  - Neurons register curr_spike at the edge that ends the FIRE cycle.
  - At the edge ending COLLECT: InternalSpike <= neuron_spikes, step_spikes <= neuron_spikes, out_valid pulses in the next cycle, and the step counter increments.
  - If the incremented count equals num_steps, go to IDLE with done pulsed and busy dropped; otherwise go to FETCH.
- cnt_i and cnt_r are 0 outside their own phase.
- InternalSpike is stable across INPUT and RECUR. It changes only at COLLECT or at start.
- Minimum timestep length: 29 cycles with defaults (FETCH 1 + LEAK 1 + 8 + 16 + 1 + 1 + COLLECT 1).
- No backpressure on out_valid. The consumer must accept the pulse.
- start asserted in the same cycle done pulses is accepted; the new sample begins.
- Rst mid-sample aborts immediately to the reset values. No done pulse is produced.
- in_valid during any phase other than FETCH is ignored; in_ready=0.

Optional Feature:
- Macro: LSM_SKIP_SILENT_EN.
- When defined:
  - INPUT is skipped (LEAK goes straight to RECUR) if the latched InputSpike == 0.
  - RECUR is skipped if InternalSpike == 0.
  - Neuron results are bit-identical to the unskipped sequence, because those phases add 0.
  - Minimum timestep becomes 5 cycles.
- When undefined: every phase always runs for its full length.

Decomposition:
- Shared package lsm_pkg:
  - 3-bit phase code constants (PH_CLEAR..PH_IDLE).
  - Default N_IN, N_RES and CNT_W.
  - The phase code constants are shared with the neuron RTL.
- One natural sub-module, lsm_index_counter:
  - Loadable 1..LIMIT up-counter with a last flag.
  - Instantiated twice, for cnt_i and cnt_r.

Test Plan:
- Reset then idle: after Rst, state=111, in_ready=0, busy=0, all counters 0. Asserting in_valid alone produces no in_ready.
- Single step: num_steps=1, in_spikes=8'h81 given immediately.
  - state sequence: 000, 111, 001, 010×8 (cnt_i 1..8), 011×16 (cnt_r 1..16), 100, 101, 110.
  - Stub neuron_spikes=16'h0005 in COLLECT gives out_valid with step_spikes=16'h0005, then done.
- Feedback path: num_steps=3 with a stub that returns 16'hA5A5 at step 0.
  - InternalSpike=16'hA5A5 throughout step 1 RECUR.
- Stall: in_valid held low for 10 cycles in FETCH.
  - state stays 111, in_ready stays 1, and the FSM proceeds the cycle after in_valid rises.
- Abort: Rst pulsed during RECUR at cnt_r=7.
  - Next cycle shows all reset values and no done. A subsequent start runs cleanly.
- num_steps=0: behaves as 1 step, and done arrives after exactly one COLLECT.
  - With LSM_SKIP_SILENT_EN and all-zero inputs, the step takes 5 cycles with no 010 or 011 codes.
